// File: rtl/fetch_unit.sv
// Instruction prefetch unit: Wishbone classic reads into a DEPTH-entry queue, at most one transfer in flight.
// Head entry is visible one cycle after the ack edge; issue stops while the queue is full, on i_disable, or after a bus error.
module fetch_unit #(
  parameter logic [31:0] INIT_PC = 32'h1000_0000,
  parameter int          DEPTH   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_disable,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [31:0]                o_instr,
  output logic [31:0]                o_pc,
  output logic                       o_err,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic [31:0]                o_wb_adr,
  output logic [3:0]                 o_wb_sel,
  output logic                       o_wb_we,
  input  logic [31:0]                i_wb_dat,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [64:0]   mem [DEPTH];
  logic [64:0]   head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_post;
  logic          resp, push, pop, issue_base;

  assign resp       = i_wb_ack | i_wb_err;
  assign o_valid    = (count != '0);
  assign pop        = o_valid & i_ready & ~i_redirect;
  assign push       = (state == REQ) & resp & ~i_redirect;
  assign count_post = count + CW'(push) - CW'(pop);
  assign issue_base = ~i_disable & ~i_redirect;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    unique case (state)
      IDLE: begin
        if (issue_base && count < DEPTH_C) state_nxt = REQ;
      end
      REQ: begin
        if (i_redirect) begin
          state_nxt = resp ? ((issue_base && count_post < DEPTH_C) ? REQ : IDLE) : DISCARD;
        end else if (i_wb_err) begin
          state_nxt = HALT;
        end else if (i_wb_ack) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = (issue_base && count_post < DEPTH_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        // A stale response retires the discard even if a new redirect lands with it.
        if (resp) state_nxt = (issue_base && count_post < DEPTH_C) ? REQ : IDLE;
      end
      HALT: begin
        if (i_redirect) state_nxt = IDLE;
      end
    endcase
    if (i_redirect) fetch_pc_nxt = i_redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      fetch_pc <= INIT_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (i_redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_post;
      end
    end
  end

  // Entry layout: {pc, instr, err}; error entries carry a zero instruction word.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {fetch_pc, (i_wb_err ? 32'h0 : i_wb_dat), i_wb_err};
  end

  assign head     = mem[rd_ptr];
  assign o_pc     = o_valid ? head[64:33] : 32'h0;
  assign o_instr  = o_valid ? head[32:1]  : 32'h0;
  assign o_err    = o_valid & head[0];
  assign o_count  = count;
  assign o_wb_cyc = (state == REQ) || (state == DISCARD);
  assign o_wb_stb = o_wb_cyc;
  assign o_wb_adr = fetch_pc;
  assign o_wb_sel = 4'hF;
  assign o_wb_we  = 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner sequences, a redirect table, and a randomized stream check.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_disable, i_redirect, i_ready;
  logic [31:0]   i_redirect_pc, i_wb_dat;
  logic          i_wb_ack, i_wb_err;
  logic          o_valid, o_err, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0]   o_instr, o_pc, o_wb_adr;
  logic [3:0]    o_wb_sel;
  logic [CW-1:0] o_count;

  fetch_unit #(.INIT_PC(32'h1000_0000), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_disable(i_disable), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_ready(i_ready), .o_valid(o_valid), .o_instr(o_instr),
    .o_pc(o_pc), .o_err(o_err), .o_count(o_count), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  always #5 i_clk = ~i_clk;

  int          n_pass = 0, n_total = 0;
  int          ack_wait = 0, wait_cnt = 0, xfers = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  typedef struct {
    logic [31:0] pc;
    int          wt;
    logic [31:0] exp_adr;
    int          exp_lat;
    logic [31:0] exp_fill;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock; then the bus slave answers the current request after ack_wait idle cycles.
  task automatic step();
    @(posedge i_clk);
    #1;
    if (!(o_wb_cyc && o_wb_stb)) begin
      i_wb_ack = 1'b0; i_wb_err = 1'b0; wait_cnt = 0;
    end else if (wait_cnt >= ack_wait) begin
      i_wb_ack = 1'b1;
      i_wb_err = err_en && (o_wb_adr == err_addr);
      i_wb_dat = i_wb_err ? 32'hBAD0_BAD0 : memf(o_wb_adr);
      wait_cnt = 0;
      xfers++;
    end else begin
      i_wb_ack = 1'b0; i_wb_err = 1'b0; wait_cnt++;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_redirect = 1'b0; i_disable = 1'b0;
    step(); step();
    i_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
    end
    check(name, o_valid, 1);
  endtask

  initial begin
    int          lat, t, pops;
    logic        redir;
    logic [31:0] exp_pc;

    vecs[0] = '{32'h2000_0006, 0, 32'h2000_0004, 2, 32'h2000_0014};
    vecs[1] = '{32'h0000_0003, 1, 32'h0000_0000, 3, 32'h0000_0010};
    vecs[2] = '{32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 2, 32'h0000_000C};
    vecs[3] = '{32'h1234_5679, 2, 32'h1234_5678, 4, 32'h1234_5688};
    vecs[4] = '{32'h8000_0001, 3, 32'h8000_0000, 5, 32'h8000_0010};
    vecs[5] = '{32'hDEAD_BEEF, 1, 32'hDEAD_BEEC, 3, 32'hDEAD_BEFC};

    i_rst_n = 1'b0; i_disable = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_ready = 1'b0; i_wb_dat = 32'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_adr", o_wb_adr, 32'h1000_0000);
    check("rst_pc", o_pc, 0);
    check("rst_instr", o_instr, 0);
    check("rst_err", o_err, 0);
    check("rst_sel", o_wb_sel, 4'hF);
    check("rst_we", o_wb_we, 0);

    // Zero-wait streaming after reset release
    step();
    i_rst_n = 1'b1; i_ready = 1'b1; ack_wait = 0;
    step();
    check("lat_cyc", o_wb_cyc, 1);
    check("lat_valid0", o_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("seq_valid", o_valid, 1);
      check("seq_pc", o_pc, 32'h1000_0000 + 32'(4 * k));
      check("seq_instr", o_instr, memf(32'h1000_0000 + 32'(4 * k)));
      check("seq_count_le1", o_count <= 1, 1);
    end

    // Reset in the middle of a transfer, then fill to DEPTH and pulse ready once
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", o_wb_cyc, 0);
    check("rst_mid_count", o_count, 0);
    check("rst_mid_valid", o_valid, 0);
    i_ready = 1'b0;
    step(); step();
    i_rst_n = 1'b1;
    xfers = 0;
    repeat (10) step();
    check("fill_xfers", xfers, 4);
    check("fill_count", o_count, 4);
    check("fill_cyc", o_wb_cyc, 0);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    repeat (9) step();
    check("pulse_xfers", xfers, 5);
    check("pulse_count", o_count, 4);
    check("pulse_cyc", o_wb_cyc, 0);
    check("pulse_head", o_pc, 32'h1000_0004);

    // Redirect while the fetch of 0x10000008 is outstanding
    ack_wait = 3;
    do_reset();
    t = 0;
    while (!(o_wb_cyc && o_wb_adr == 32'h1000_0008) && t < 40) begin
      step();
      t++;
    end
    check("disc_reach", o_wb_adr, 32'h1000_0008);
    i_redirect = 1'b1; i_redirect_pc = 32'h2000_0006;
    step();
    i_redirect = 1'b0;
    check("disc_cyc", o_wb_cyc, 1);
    check("disc_adr", o_wb_adr, 32'h2000_0004);
    check("disc_count", o_count, 0);
    wait_valid("disc_wait", lat);
    check("disc_head_pc", o_pc, 32'h2000_0004);
    check("disc_head_instr", o_instr, memf(32'h2000_0004));
    check("disc_head_err", o_err, 0);

    // Bus error on 0x1000000C halts fetch until a redirect
    ack_wait = 0; err_en = 1'b1; err_addr = 32'h1000_000C;
    do_reset();
    xfers = 0;
    repeat (10) step();
    check("halt_xfers", xfers, 4);
    check("halt_count", o_count, 4);
    check("halt_cyc", o_wb_cyc, 0);
    check("halt_adr", o_wb_adr, 32'h1000_000C);
    i_ready = 1'b1;
    repeat (3) step();
    i_ready = 1'b0;
    check("halt_head_err", o_err, 1);
    check("halt_head_pc", o_pc, 32'h1000_000C);
    check("halt_head_instr", o_instr, 0);
    repeat (5) step();
    check("halt_idle_cyc", o_wb_cyc, 0);
    check("halt_idle_xfers", xfers, 4);
    err_en = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 32'h0;
    step();
    i_redirect = 1'b0;
    wait_valid("resume_wait", lat);
    check("resume_pc", o_pc, 0);
    check("resume_err", o_err, 0);
    check("resume_instr", o_instr, memf(32'h0));

    // Disable during an outstanding transfer lets it finish, then blocks issue
    ack_wait = 3;
    do_reset();
    xfers = 0;
    step();
    check("dis_cyc_start", o_wb_cyc, 1);
    i_disable = 1'b1;
    repeat (10) step();
    check("dis_xfers", xfers, 1);
    check("dis_count", o_count, 1);
    check("dis_cyc", o_wb_cyc, 0);
    check("dis_head", o_pc, 32'h1000_0000);
    i_disable = 1'b0;
    step();
    check("dis_resume_cyc", o_wb_cyc, 1);
    check("dis_resume_adr", o_wb_adr, 32'h1000_0004);

    // Push, pop and redirect on the same edge
    ack_wait = 0; i_ready = 1'b1;
    do_reset();
    step(); step(); step();
    check("ppr_pre_count", o_count, 1);
    check("ppr_pre_cyc", o_wb_cyc, 1);
    i_redirect = 1'b1; i_redirect_pc = 32'h3000_0010;
    step();
    i_redirect = 1'b0;
    check("ppr_count", o_count, 0);
    check("ppr_adr", o_wb_adr, 32'h3000_0010);
    check("ppr_valid", o_valid, 0);

    // Redirect table: start each vector from a full, idle queue
    i_ready = 1'b0; ack_wait = 0;
    do_reset();
    repeat (10) step();
    for (int v = 0; v < 6; v++) begin
      ack_wait = vecs[v].wt;
      i_redirect = 1'b1; i_redirect_pc = vecs[v].pc;
      step();
      i_redirect = 1'b0;
      check("tbl_count0", o_count, 0);
      check("tbl_adr", o_wb_adr, vecs[v].exp_adr);
      wait_valid("tbl_wait", lat);
      check("tbl_lat", lat, vecs[v].exp_lat);
      check("tbl_pc", o_pc, vecs[v].exp_adr);
      check("tbl_instr", o_instr, memf(vecs[v].exp_adr));
      t = 0;
      while (!(o_count == 4 && !o_wb_cyc) && t < 60) begin
        step();
        t++;
      end
      check("tbl_full", o_count, 4);
      check("tbl_fill_adr", o_wb_adr, vecs[v].exp_fill);
    end

    // Random traffic: popped entries must follow the sequential stream restarted at each redirect
    i_redirect = 1'b1; i_redirect_pc = 32'h4000_0000;
    step();
    i_redirect = 1'b0;
    exp_pc = 32'h4000_0000;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      i_ready   = ($urandom_range(0, 9) < 7);
      i_disable = ($urandom_range(0, 19) == 0);
      ack_wait  = $urandom_range(0, 2);
      redir     = ($urandom_range(0, 49) == 0);
      i_redirect = redir;
      if (redir) i_redirect_pc = $urandom;
      if (o_valid && i_ready && !i_redirect) begin
        check("rnd_pc", o_pc, exp_pc);
        check("rnd_instr", o_instr, memf(exp_pc));
        check("rnd_err", o_err, 0);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      step();
      if (redir) begin
        exp_pc = {i_redirect_pc[31:2], 2'b00};
        i_redirect = 1'b0;
      end
      check("rnd_inv", {29'd0, o_valid == (o_count != 0), o_count <= DEPTH,
                        (o_valid || (o_pc == 0 && o_instr == 0 && !o_err))}, 32'd7);
    end
    check("rnd_progress", pops > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
